// File: rtl/cpu_bus_arbiter.sv
// Hands 8501 bus ownership to one of two DMA requesters: rdy drops first, aec
// follows BA_LEAD enables later (or earlier on a CPU read with EARLY_GRANT).
module cpu_bus_arbiter #(
  parameter int BA_LEAD     = 3,
  parameter int EARLY_GRANT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cpu_rw,
  input  logic [1:0] req,
  output logic       rdy,
  output logic       aec,
  output logic [1:0] grant,
  output logic       bus_busy
);

  localparam int CW = $clog2(BA_LEAD + 1);
  localparam logic [CW-1:0] LEAD = CW'(BA_LEAD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALT = 2'd1,
    OWN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          aec_q, aec_d;
  logic [1:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          winner_q, winner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Fixed priority: whoever is requesting now with req[0] preferred.
  logic          pick;
  logic          other;
  logic          grant_now;

  assign pick      = req[0] ? 1'b0 : 1'b1;
  assign other     = ~winner_q;
  assign grant_now = (cnt_q == LEAD) || ((EARLY_GRANT != 0) && cpu_rw);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b1;
      aec_q    <= 1'b1;
      grant_q  <= 2'b00;
      busy_q   <= 1'b0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      aec_q    <= aec_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rdy_d    = rdy_q;
    aec_d    = aec_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;

    if (enable) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (req != 2'b00) begin
            winner_d = pick;
            rdy_d    = 1'b0;
            cnt_d    = CW'(1);
            busy_d   = 1'b1;
            state_d  = HALT;
          end
        end

        HALT: begin
          if (req == 2'b00) begin
            rdy_d   = 1'b1;
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // Winner may change while halting; the lead count keeps running.
            winner_d = pick;
            if (grant_now) begin
              aec_d   = 1'b0;
              grant_d = pick ? 2'b10 : 2'b01;
              state_d = OWN;
            end else if (cnt_q < LEAD) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end

        OWN: begin
          if (!req[winner_q]) begin
            if (req[other]) begin
              // Handover without giving the CPU a cycle in between.
              winner_d = other;
              grant_d  = other ? 2'b10 : 2'b01;
            end else begin
              aec_d   = 1'b1;
              rdy_d   = 1'b1;
              grant_d = 2'b00;
              cnt_d   = '0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end

        default: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          aec_d   = 1'b1;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign rdy      = rdy_q;
  assign aec      = aec_q;
  assign grant    = grant_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: default instance plus an EARLY_GRANT
// instance with a longer lead so the early grant is distinguishable.
module tb_cpu_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       cpu_rw;
  logic [1:0] req;
  logic [1:0] req_eg;

  logic       rdy, aec, bus_busy;
  logic [1:0] grant;
  logic       rdy_eg, aec_eg, bus_busy_eg;
  logic [1:0] grant_eg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.BA_LEAD(3), .EARLY_GRANT(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cpu_rw(cpu_rw), .req(req),
    .rdy(rdy), .aec(aec), .grant(grant), .bus_busy(bus_busy)
  );

  cpu_bus_arbiter #(.BA_LEAD(5), .EARLY_GRANT(1)) dut_eg (
    .clk(clk), .reset(reset), .enable(enable), .cpu_rw(cpu_rw), .req(req_eg),
    .rdy(rdy_eg), .aec(aec_eg), .grant(grant_eg), .bus_busy(bus_busy_eg)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got busy/rdy/aec/grant=%b expected %b", tag, got, exp);
    end
  endtask

  // Expected values packed as {bus_busy, rdy, aec, grant}.
  task automatic expect_main(input string tag, input logic [4:0] exp);
    check(tag, {bus_busy, rdy, aec, grant}, exp);
  endtask

  task automatic expect_eg(input string tag, input logic [4:0] exp);
    check(tag, {bus_busy_eg, rdy_eg, aec_eg, grant_eg}, exp);
  endtask

  // One-clk enable strobe; returns at a negedge, well after the active edge.
  task automatic pulse_enable();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [4:0] S_IDLE = 5'b0_1_1_00;
  localparam logic [4:0] S_HALT = 5'b1_0_1_00;
  localparam logic [4:0] S_OWN0 = 5'b1_0_0_01;
  localparam logic [4:0] S_OWN1 = 5'b1_0_0_10;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    cpu_rw = 1'b0;
    req    = 2'b00;
    req_eg = 2'b00;
    repeat (3) @(negedge clk);
    expect_main("reset_state", S_IDLE);
    expect_eg("reset_state_eg", S_IDLE);
    reset = 1'b0;
    @(negedge clk);

    // Basic grant with default lead of 3.
    req = 2'b01;
    pulse_enable(); expect_main("t2_en1_halt", S_HALT);
    pulse_enable(); expect_main("t2_en2_halt", S_HALT);
    pulse_enable(); expect_main("t2_en3_halt", S_HALT);
    pulse_enable(); expect_main("t2_en4_own", S_OWN0);
    pulse_enable(); expect_main("t2_held_own", S_OWN0);
    req = 2'b00;
    pulse_enable(); expect_main("t2_release", S_IDLE);

    // Short pulse aborts HALT; cpu_rw=1 must not grant early here.
    cpu_rw = 1'b1;
    req = 2'b01;
    pulse_enable(); expect_main("t4_en1_halt", S_HALT);
    pulse_enable(); expect_main("t4_en2_halt", S_HALT);
    req = 2'b00;
    pulse_enable(); expect_main("t4_abort", S_IDLE);
    cpu_rw = 1'b0;

    // Priority switch in HALT, then handovers in OWN.
    req = 2'b10;
    pulse_enable(); expect_main("t3_en1_halt", S_HALT);
    req = 2'b11;
    pulse_enable(); expect_main("t3_en2_halt", S_HALT);
    pulse_enable(); expect_main("t3_en3_halt", S_HALT);
    pulse_enable(); expect_main("t3_en4_grant0", S_OWN0);
    req = 2'b10;
    pulse_enable(); expect_main("t3_handover_1", S_OWN1);
    req = 2'b11;
    pulse_enable(); expect_main("t3_no_preempt", S_OWN1);
    req = 2'b01;
    pulse_enable(); expect_main("t3_handover_0", S_OWN0);
    req = 2'b00;
    pulse_enable(); expect_main("t3_release", S_IDLE);
    req = 2'b01;
    pulse_enable(); expect_main("t3_reenter_halt", S_HALT);
    req = 2'b00;
    pulse_enable(); expect_main("t3_reenter_abort", S_IDLE);

    // Early grant on first read enable in HALT (lead 5 would not expire yet).
    req_eg = 2'b01;
    cpu_rw = 1'b0;
    pulse_enable(); expect_eg("t5_idle_to_halt", S_HALT);
    pulse_enable(); expect_eg("t5_halt1_write", S_HALT);
    pulse_enable(); expect_eg("t5_halt2_write", S_HALT);
    cpu_rw = 1'b1;
    pulse_enable(); expect_eg("t5_halt3_read_grant", S_OWN0);
    expect_main("t5_main_untouched", S_IDLE);
    req_eg = 2'b00;
    cpu_rw = 1'b0;
    pulse_enable(); expect_eg("t5_release", S_IDLE);

    // No enable: nothing moves even with both requests up.
    req = 2'b11;
    repeat (10) @(negedge clk);
    expect_main("t6_hold_mid", S_IDLE);
    repeat (10) @(negedge clk);
    expect_main("t6_hold_end", S_IDLE);

    // Into OWN, then asynchronous reset between clock edges.
    pulse_enable(); expect_main("t1_halt", S_HALT);
    pulse_enable();
    pulse_enable();
    pulse_enable(); expect_main("t1_own", S_OWN0);
    #2 reset = 1'b1;
    #1 expect_main("t1_async_reset", S_IDLE);
    @(negedge clk);
    req = 2'b00;
    reset = 1'b0;
    pulse_enable(); expect_main("t1_after_reset", S_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
